// File: rtl/planta_bomba_recalque.sv
// Cistern -> water-tank plant model: integrates levels and produces level sensors and misuse alarms.
// Optional macro PLANTA_FALHA_SENSOR_EN adds falha_sensor, which forces an inconsistent tank sensor pair.
module planta_bomba_recalque #(
  parameter int unsigned NBITS_NIVEL   = 8,
  parameter int unsigned CAIXA_CAP     = 100,
  parameter int unsigned CAIXA_MIN     = 20,
  parameter int unsigned CISTERNA_CAP  = 200,
  parameter int unsigned CISTERNA_MIN  = 10,
  parameter int unsigned CAIXA_INIT    = 0,
  parameter int unsigned CISTERNA_INIT = 200,
  parameter int unsigned PUMP_DIV      = 4,
  parameter int unsigned CONSUMO_DIV   = 8,
  parameter int unsigned ABAST_DIV     = 2
) (
  input  logic                   clk_2,
  input  logic                   reset,
  input  logic                   bomba_acionada,
  input  logic                   consumo,
  input  logic                   abastecimento,
`ifdef PLANTA_FALHA_SENSOR_EN
  input  logic                   falha_sensor,
`endif
  output logic                   cisterna_nivel_min,
  output logic                   caixa_nivel_min,
  output logic                   caixa_nivel_max,
  output logic [NBITS_NIVEL-1:0] nivel_caixa,
  output logic [NBITS_NIVEL-1:0] nivel_cisterna,
  output logic                   alarme_seco,
  output logic                   alarme_transbordo
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {REPOUSO, ENCHENDO, A_SECO, TRANSBORDO} estado_t;

  logic [CNT_W-1:0]       pump_cnt_q, pump_cnt_d;
  logic [CNT_W-1:0]       cons_cnt_q, cons_cnt_d;
  logic [CNT_W-1:0]       abast_cnt_q, abast_cnt_d;
  logic [NBITS_NIVEL-1:0] caixa_q, caixa_d;
  logic [NBITS_NIVEL-1:0] cist_q, cist_d;
  estado_t                state_q;

  logic pump_ev, cons_ev, abast_ev, pump_ok;
  logic cist_vazia, caixa_cheia;

  assign cist_vazia  = (cist_q == '0);
  assign caixa_cheia = (caixa_q == NBITS_NIVEL'(CAIXA_CAP));

  // A unit moves on the DIV-th consecutive enabled edge; dropping the enable discards the partial count
  assign pump_ev  = bomba_acionada && (pump_cnt_q  == CNT_W'(PUMP_DIV - 1));
  assign cons_ev  = consumo        && (cons_cnt_q  == CNT_W'(CONSUMO_DIV - 1));
  assign abast_ev = abastecimento  && (abast_cnt_q == CNT_W'(ABAST_DIV - 1));
  assign pump_ok  = pump_ev && !cist_vazia && !caixa_cheia;

  always_comb begin
    pump_cnt_d  = (!bomba_acionada || pump_ev) ? '0 : pump_cnt_q + CNT_W'(1);
    cons_cnt_d  = (!consumo || cons_ev)        ? '0 : cons_cnt_q + CNT_W'(1);
    abast_cnt_d = (!abastecimento || abast_ev) ? '0 : abast_cnt_q + CNT_W'(1);
    caixa_d     = caixa_q;
    cist_d      = cist_q;
    // Net delta per tank, saturating at 0 and at the cap
    if (pump_ok && !cons_ev) begin
      caixa_d = caixa_q + NBITS_NIVEL'(1);
    end else if (cons_ev && !pump_ok && (caixa_q != '0)) begin
      caixa_d = caixa_q - NBITS_NIVEL'(1);
    end
    if (pump_ok && !abast_ev) begin
      cist_d = cist_q - NBITS_NIVEL'(1);
    end else if (abast_ev && !pump_ok && (cist_q != NBITS_NIVEL'(CISTERNA_CAP))) begin
      cist_d = cist_q + NBITS_NIVEL'(1);
    end
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      pump_cnt_q  <= '0;
      cons_cnt_q  <= '0;
      abast_cnt_q <= '0;
      caixa_q     <= NBITS_NIVEL'(CAIXA_INIT);
      cist_q      <= NBITS_NIVEL'(CISTERNA_INIT);
    end else begin
      pump_cnt_q  <= pump_cnt_d;
      cons_cnt_q  <= cons_cnt_d;
      abast_cnt_q <= abast_cnt_d;
      caixa_q     <= caixa_d;
      cist_q      <= cist_d;
    end
  end

  // Pump-usage FSM judged on the pre-update levels; dry running outranks overflow
  always_ff @(posedge clk_2) begin
    if (reset) begin
      state_q <= REPOUSO;
    end else if (!bomba_acionada) begin
      state_q <= REPOUSO;
    end else if (cist_vazia) begin
      state_q <= A_SECO;
    end else if (caixa_cheia) begin
      state_q <= TRANSBORDO;
    end else begin
      state_q <= ENCHENDO;
    end
  end

  assign alarme_seco       = (state_q == A_SECO);
  assign alarme_transbordo = (state_q == TRANSBORDO);

  assign nivel_caixa        = caixa_q;
  assign nivel_cisterna     = cist_q;
  assign cisterna_nivel_min = (cist_q >= NBITS_NIVEL'(CISTERNA_MIN));

`ifdef PLANTA_FALHA_SENSOR_EN
  assign caixa_nivel_min = !falha_sensor && (caixa_q >= NBITS_NIVEL'(CAIXA_MIN));
  assign caixa_nivel_max = falha_sensor || caixa_cheia;
`else
  assign caixa_nivel_min = (caixa_q >= NBITS_NIVEL'(CAIXA_MIN));
  assign caixa_nivel_max = caixa_cheia;
`endif

endmodule

// File: tb/tb_planta_bomba_recalque.sv
// Bench for planta_bomba_recalque: directed scenarios plus randomized traffic against a run-length level model.
module tb_planta_bomba_recalque;

  localparam int CAIXA_CAP    = 100;
  localparam int CAIXA_MIN    = 20;
  localparam int CIST_CAP     = 200;
  localparam int CIST_MIN     = 10;
  localparam int CAIXA_INIT   = 0;
  localparam int CIST_INIT    = 200;
  localparam int PUMP_DIV     = 4;
  localparam int CONS_DIV     = 8;
  localparam int ABAST_DIV    = 2;

  logic clk_2 = 1'b0;
  logic reset, bomba, consumo, abast, falha;
  logic cist_min, caixa_min, caixa_max, seco, transb;
  logic [7:0] n_caixa, n_cist;
  logic s_cist_min, s_caixa_min, s_caixa_max, s_seco, s_transb;
  logic [7:0] s_caixa, s_cist;

  int checks = 0;
  int errors = 0;

  int m_caixa, m_cist, m_rp, m_rc, m_ra;
  bit m_seco, m_transb;

  always #5 clk_2 = ~clk_2;

  planta_bomba_recalque u_dut (
    .clk_2(clk_2), .reset(reset), .bomba_acionada(bomba), .consumo(consumo),
    .abastecimento(abast),
`ifdef PLANTA_FALHA_SENSOR_EN
    .falha_sensor(falha),
`endif
    .cisterna_nivel_min(cist_min), .caixa_nivel_min(caixa_min), .caixa_nivel_max(caixa_max),
    .nivel_caixa(n_caixa), .nivel_cisterna(n_cist),
    .alarme_seco(seco), .alarme_transbordo(transb)
  );

  // Small cistern to reach dry running quickly
  planta_bomba_recalque #(.CISTERNA_INIT(5)) u_seco (
    .clk_2(clk_2), .reset(reset), .bomba_acionada(bomba), .consumo(consumo),
    .abastecimento(abast),
`ifdef PLANTA_FALHA_SENSOR_EN
    .falha_sensor(1'b0),
`endif
    .cisterna_nivel_min(s_cist_min), .caixa_nivel_min(s_caixa_min), .caixa_nivel_max(s_caixa_max),
    .nivel_caixa(s_caixa), .nivel_cisterna(s_cist),
    .alarme_seco(s_seco), .alarme_transbordo(s_transb)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int clamp(input int v, input int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  // Reference: an event every DIV-th cycle of an unbroken enable run; limits judged on pre-cycle levels
  task automatic model_update(input bit r, input bit b, input bit c, input bit a);
    bit pe, ce, ae, pok;
    if (r) begin
      m_caixa = CAIXA_INIT; m_cist = CIST_INIT;
      m_rp = 0; m_rc = 0; m_ra = 0;
      m_seco = 0; m_transb = 0;
    end else begin
      m_seco   = b && (m_cist == 0);
      m_transb = b && (m_cist > 0) && (m_caixa == CAIXA_CAP);
      m_rp = b ? m_rp + 1 : 0;
      m_rc = c ? m_rc + 1 : 0;
      m_ra = a ? m_ra + 1 : 0;
      pe = b && (m_rp % PUMP_DIV == 0);
      ce = c && (m_rc % CONS_DIV == 0);
      ae = a && (m_ra % ABAST_DIV == 0);
      pok = pe && (m_cist > 0) && (m_caixa < CAIXA_CAP);
      m_caixa = clamp(m_caixa + int'(pok) - int'(ce), CAIXA_CAP);
      m_cist  = clamp(m_cist - int'(pok) + int'(ae), CIST_CAP);
    end
  endtask

  task automatic compare_all();
    check("nivel_caixa", 32'(n_caixa), 32'(m_caixa));
    check("nivel_cisterna", 32'(n_cist), 32'(m_cist));
    check("cisterna_nivel_min", 32'(cist_min), 32'(m_cist >= CIST_MIN));
    check("caixa_nivel_min", 32'(caixa_min), 32'(!falha && (m_caixa >= CAIXA_MIN)));
    check("caixa_nivel_max", 32'(caixa_max), 32'(falha || (m_caixa == CAIXA_CAP)));
    check("alarme_seco", 32'(seco), 32'(m_seco));
    check("alarme_transbordo", 32'(transb), 32'(m_transb));
  endtask

  task automatic step(input bit r, input bit b, input bit c, input bit a);
    reset = r; bomba = b; consumo = c; abast = a;
    @(posedge clk_2);
    model_update(r, b, c, a);
    #1;
    compare_all();
  endtask

  initial begin
    bit r, b, c, a;
    reset = 1'b1; bomba = 1'b0; consumo = 1'b0; abast = 1'b0; falha = 1'b0;
    #1;
    step(1, 0, 0, 0);
    check("rst_caixa", 32'(n_caixa), 32'd0);
    check("rst_cist", 32'(n_cist), 32'd200);
    check("rst_cist_min", 32'(cist_min), 32'd1);
    check("seco_rst_cist_min", 32'(s_cist_min), 32'd0);

    // Dry running on the small-cistern instance
    repeat (20) step(0, 1, 0, 0);
    check("seco_cist0", 32'(s_cist), 32'd0);
    check("seco_caixa5", 32'(s_caixa), 32'd5);
    check("seco_alarm_not_yet", 32'(s_seco), 32'd0);
    step(0, 1, 0, 0);
    check("seco_alarm_on", 32'(s_seco), 32'd1);
    check("seco_no_transb", 32'(s_transb), 32'd0);
    repeat (2) step(0, 1, 0, 1);
    check("seco_refill", 32'(s_cist), 32'd1);
    check("seco_alarm_held", 32'(s_seco), 32'd1);
    step(0, 1, 0, 0);
    check("seco_alarm_clear", 32'(s_seco), 32'd0);

    // Fill to the min sensor, then a broken pump run
    step(1, 0, 0, 0);
    repeat (79) step(0, 1, 0, 0);
    check("fill79_caixa_min", 32'(caixa_min), 32'd0);
    step(0, 1, 0, 0);
    check("fill80_caixa", 32'(n_caixa), 32'd20);
    check("fill80_cist", 32'(n_cist), 32'd180);
    check("fill80_caixa_min", 32'(caixa_min), 32'd1);
    repeat (3) step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    repeat (3) step(0, 1, 0, 0);
    check("partial_cleared", 32'(n_caixa), 32'd20);
    step(0, 1, 0, 0);
    check("after_clear_unit", 32'(n_caixa), 32'd21);

    // Overflow
    repeat (400) step(0, 1, 0, 0);
    check("full_caixa", 32'(n_caixa), 32'd100);
    check("full_cist", 32'(n_cist), 32'd100);
    check("full_max", 32'(caixa_max), 32'd1);
    check("transb_on", 32'(transb), 32'd1);
    step(0, 0, 0, 0);
    check("transb_off", 32'(transb), 32'd0);

    // Pump plus consumo from a half tank
    step(1, 0, 0, 0);
    repeat (200) step(0, 1, 0, 0);
    check("half_caixa", 32'(n_caixa), 32'd50);
    repeat (8) step(0, 1, 1, 0);
    check("mix_caixa", 32'(n_caixa), 32'd51);
    check("mix_cist", 32'(n_cist), 32'd148);

`ifdef PLANTA_FALHA_SENSOR_EN
    falha = 1'b1;
    step(0, 0, 0, 0);
    check("falha_max", 32'(caixa_max), 32'd1);
    check("falha_min", 32'(caixa_min), 32'd0);
    falha = 1'b0;
    step(0, 0, 0, 0);
    check("falha_rel_max", 32'(caixa_max), 32'd0);
    check("falha_rel_min", 32'(caixa_min), 32'd1);
`endif

    // Reset in the middle of a run
    repeat (5) step(0, 1, 1, 1);
    step(1, 1, 1, 1);
    check("midrst_caixa", 32'(n_caixa), 32'd0);
    check("midrst_cist", 32'(n_cist), 32'd200);
    repeat (3) step(0, 1, 0, 0);
    check("midrst_cnt_cleared", 32'(n_caixa), 32'd0);
    step(0, 1, 0, 0);
    check("midrst_first_unit", 32'(n_caixa), 32'd1);

    // Randomized traffic with sticky enables so divider runs complete
    b = 1; c = 0; a = 0;
    repeat (4000) begin
      if ($urandom_range(0, 7) == 0) b = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 7) == 0) c = ($urandom_range(0, 9) < 4);
      if ($urandom_range(0, 7) == 0) a = ($urandom_range(0, 9) < 4);
      r = ($urandom_range(0, 999) == 0);
      step(r, b, c, a);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/planta_bomba_recalque.md
Name: planta_bomba_recalque

Overview:
- Cycle-level plant model of the cistern → water-tank system, built for the FPGA board.
- Takes the pump command and drain/refill stimuli; integrates water levels in counters; produces the three level-sensor signals a pump controller consumes.
- Closes the loop with the pump-control FSM for on-board demos (level shown on LEDs/LCD).
- Flags dry-running and overflow pump misuse.

Parameters:
NBITS_NIVEL, 8, width of level counters and level outputs
CAIXA_CAP, 100, tank capacity in units; full = level == CAIXA_CAP
CAIXA_MIN, 20, tank min-sensor threshold
CISTERNA_CAP, 200, cistern capacity in units
CISTERNA_MIN, 10, cistern min-sensor threshold
CAIXA_INIT, 0, tank level after reset
CISTERNA_INIT, 200, cistern level after reset
PUMP_DIV, 4, cycles of pump-on per unit transferred
CONSUMO_DIV, 8, cycles of consumo per unit drained from tank
ABAST_DIV, 2, cycles of abastecimento per unit added to cistern

Ports:
clk_2  in  1  clock
reset  in  1  synchronous reset, active-high
bomba_acionada  in  1  pump command from controller
consumo  in  1  household draw active (drains tank)
abastecimento  in  1  street supply active (fills cistern)
cisterna_nivel_min  out  1  cistern level >= CISTERNA_MIN
caixa_nivel_min  out  1  tank level >= CAIXA_MIN
caixa_nivel_max  out  1  tank level == CAIXA_CAP
nivel_caixa  out  NBITS_NIVEL  current tank level
nivel_cisterna  out  NBITS_NIVEL  current cistern level
alarme_seco  out  1  pump on with empty cistern
alarme_transbordo  out  1  pump on with full tank

Behaviour:
- Single clock, clk_2. reset is synchronous and active-high, sampled on posedge clk_2.
- Reset values:
  - nivel_caixa = CAIXA_INIT; nivel_cisterna = CISTERNA_INIT.
  - All divider counters = 0; state = REPOUSO; both alarms = 0.
  - Sensor outputs follow the reset levels (default: cist_min=1, caixa_min=0, caixa_max=0).
- Reset mid-operation:
  - Discards all partial divider counts.
  - Takes priority over every other event in the same cycle.
- Divider counters: pump_cnt, cons_cnt, abast_cnt.
  - Each counts only while its enable (bomba_acionada / consumo / abastecimento) is 1.
  - Each clears to 0 the cycle its enable is 0.
  - Event fires when cnt == DIV-1 with enable=1; cnt then returns to 0.
  - First unit therefore moves on the DIV-th consecutive enabled edge.
- Pump transfer event:
  - If nivel_cisterna > 0 and nivel_caixa < CAIXA_CAP: cisterna -1, caixa +1.
  - Otherwise levels are unchanged and the count is still consumed.
- Consumo event: caixa -1 if > 0, else unchanged.
- Abastecimento event: cisterna +1 if < CISTERNA_CAP, else unchanged.
- Simultaneous events in one cycle:
  - Compute the net delta per tank, evaluating limits against the pre-cycle level.
  - Pump blocked by full tank + consumo in the same cycle: pump remains blocked; tank -1.
  - Pump + consumo with transfer allowed: tank net 0, cistern -1.
  - Pump + abastecimento with transfer allowed: cistern net 0 (saturates at CISTERNA_CAP), tank +1.
- No wrap-around: levels saturate at 0 and at their caps.
- Sensor outputs are combinational compares of the registered levels; they change in the same cycle the level register updates.
- State machine, registered; next state is computed from bomba_acionada and the current levels:
  - REPOUSO: bomba=0.
  - ENCHENDO: bomba=1, cisterna>0, caixa<CAIXA_CAP.
  - A_SECO: bomba=1, cisterna==0. Takes priority over TRANSBORDO.
  - TRANSBORDO: bomba=1, caixa==CAIXA_CAP, cisterna>0.
  - Any state can reach any other directly.
- Alarms are registered decodes: alarme_seco = (state==A_SECO); alarme_transbordo = (state==TRANSBORDO).
  - Each asserts one cycle after the offending level is reached with the pump on.
  - Each deasserts one cycle after bomba drops or the condition clears.

Optional Feature:
- Macro: PLANTA_FALHA_SENSOR_EN.
- Defined:
  - Adds input falha_sensor (1 bit).
  - While falha_sensor=1, caixa_nivel_max is forced to 1 and caixa_nivel_min to 0. This is an inconsistent pair, used to exercise controller fault handling.
  - Levels, dividers and alarms are unaffected.
- Undefined: no port; sensors are always the true compares.

Test Plan:
- Reset, all inputs 0 → nivel_caixa=0, nivel_cisterna=200, cist_min=1, caixa_min=0, caixa_max=0, alarms 0.
- bomba=1 for 80 cycles → caixa=20, cisterna=180, caixa_min rises on the 80th edge; 3 cycles bomba then 1 cycle off → no transfer, pump_cnt cleared.
- bomba=1 for 400 cycles → caixa=100, caixa_max=1; alarme_transbordo=1 one cycle later; further pumping leaves cisterna=100; bomba=0 → alarm 0 next cycle.
- CISTERNA_INIT=5, bomba=1 → cist_min=0 from reset; after 20 cycles cisterna=0, caixa=5; alarme_seco=1 on the next cycle; abastecimento=1 for 2 cycles → cisterna=1, alarm clears the cycle after.
- Tank at 50, bomba=1 and consumo=1 for 8 cycles → caixa=51 (2 in, 1 out), cisterna -2; reset asserted at cycle 5 of a run → levels return to INIT values, all counters 0.
- PLANTA_FALHA_SENSOR_EN defined, caixa=50, falha_sensor=1 → caixa_max=1, caixa_min=0; release → caixa_max=0, caixa_min=1.
